counter_updn_mod: RTL and testbench

//   Parametrised up/down modulo counter; successor to the fixed 4-bit up-counter.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_prescaler.sv | 56 +++++
 rtl/counter_updn_mod.sv | 154 +++++++++++++++
 tb/tb_counter_updn_mod.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared constants and helpers for the up/down modulo counter family.
//   MODE_WRAP / MODE_SAT  : values for the SAT_MODE parameter
//   clog2_min1(n)         : ceil(log2(n)), never less than 1, used to size
//                           the prescaler phase register
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold 0..n-1, clamped to at least one bit so that a
    // degenerate divide-by-one still yields a legal vector declaration.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(n)) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
//   Divides the enable stream: produces one step for every PRESCALE cycles
//   in which en is high. Cycles with en low freeze the phase, so a gap in
//   enable delays the next step by exactly the length of the gap.
// Parameters
//   PRESCALE : enabled cycles per step, >= 1 (1 = step follows en directly)
// Ports
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset, clears the phase
//   en   in  advance the phase this cycle
//   clr  in  synchronous clear of the phase (used by parallel load)
//   step out high in the enabled cycle that completes an interval
// ---------------------------------------------------------------------------
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // No state needed: every enabled cycle is a step.
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clr};
            assign step     = en;
        end else begin : g_div
            localparam int            PW   = clog2_min1(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] r_phase;
            logic          w_last;

            assign w_last = (r_phase == LAST);

            // Phase counts enabled cycles and rolls over when a step fires;
            // reset and clear discard any partial interval.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_phase <= '0;
                end else if (en) begin
                    r_phase <= w_last ? '0 : r_phase + 1'b1;
                end
            end

            assign step = en & w_last;
        end
    endgenerate

endmodule

// File: rtl/counter_updn_mod.sv
// ---------------------------------------------------------------------------
// counter_updn_mod
//   Parametrised up/down modulo counter with parallel load, wrap or
//   saturate behaviour at the range limits, an enable prescaler and a
//   registered terminal-count pulse.
// Parameters
//   WIDTH    : counter width in bits
//   MAX_VAL  : top of the count range (range is 0..MAX_VAL)
//   SAT_MODE : MODE_WRAP (0) wraps at the limits, MODE_SAT (1) holds
//   PRESCALE : enabled cycles per count step
//   RST_VAL  : count value after reset
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   count enable, advances the prescaler
//   up         in   direction, 1 = up, 0 = down
//   load       in   synchronous parallel load (beats stepping)
//   load_val   in   value to load, clamped to MAX_VAL
//   count_out  out  registered count
//   tc         out  one-cycle pulse after a step taken at a limit
//   ovf_clr    in   clears ovf_sticky       (COUNTER_STICKY_OVF_EN only)
//   ovf_sticky out  latched limit event     (COUNTER_STICKY_OVF_EN only)
// Build option
//   COUNTER_STICKY_OVF_EN : adds the sticky overflow flag and its clear
// ---------------------------------------------------------------------------
module counter_updn_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SAT_MODE = MODE_WRAP,
    parameter int PRESCALE = 1,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc
`ifdef COUNTER_STICKY_OVF_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf_sticky
`endif
);

    // Reject parameter sets that would make the range or reset value illegal.
    generate
        if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1) begin : g_err_max
            $error("counter_updn_mod: MAX_VAL out of range 1..2**WIDTH-1");
        end
        if (PRESCALE < 1) begin : g_err_pre
            $error("counter_updn_mod: PRESCALE must be >= 1");
        end
        if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_err_rst
            $error("counter_updn_mod: RST_VAL must lie in 0..MAX_VAL");
        end
        if (SAT_MODE != MODE_WRAP && SAT_MODE != MODE_SAT) begin : g_err_mode
            $error("counter_updn_mod: SAT_MODE must be MODE_WRAP or MODE_SAT");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    localparam bit               SAT   = (SAT_MODE == MODE_SAT);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_step;
    logic             w_atLimit;
    logic             w_limitEvent;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_loadClamped;

    // A load restarts the prescale interval so the first step after a load
    // always comes a full interval later.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (w_step)
    );

    // The limit depends on direction: MAX_VAL going up, zero going down.
    // At the limit the next value is the opposite end (wrap) or the same
    // value (saturate); otherwise a plain +/-1 that never leaves the range.
    always_comb begin
        w_atLimit = up ? (r_count == MAX_W) : (r_count == '0);
        w_next    = r_count;
        if (up) begin
            if (!w_atLimit) begin
                w_next = r_count + 1'b1;
            end else if (!SAT) begin
                w_next = '0;
            end
        end else begin
            if (!w_atLimit) begin
                w_next = r_count - 1'b1;
            end else if (!SAT) begin
                w_next = MAX_W;
            end
        end
        w_loadClamped = (load_val > MAX_W) ? MAX_W : load_val;
    end

    assign w_limitEvent = w_step & ~load & w_atLimit;

    // Count and terminal-count register: reset beats load beats step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RST_W;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_loadClamped;
            r_tc    <= 1'b0;
        end else if (w_step) begin
            r_count <= w_next;
            r_tc    <= w_atLimit;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count_out = r_count;
    assign tc        = r_tc;

`ifdef COUNTER_STICKY_OVF_EN
    logic r_ovfSticky;

    // Setting has priority over clearing so a limit event coinciding with
    // a clear is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovfSticky <= 1'b0;
        end else if (w_limitEvent) begin
            r_ovfSticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovfSticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovfSticky;
`else
    logic w_unusedLimit;
    assign w_unusedLimit = w_limitEvent;
`endif

endmodule

// File: tb/tb_counter_updn_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_updn_mod
//   Directed bench for counter_updn_mod. Four instances share one set of
//   inputs: default wrap counter (A), MAX_VAL=11 (B), PRESCALE=3 (C) and
//   saturating counter (D). Each section resets all of them and then only
//   looks at the instance it is about.
// ---------------------------------------------------------------------------
module tb_counter_updn_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] loadVal = 4'd0;
    logic       ovfClr = 1'b0;

    logic [3:0] countA, countB, countC, countD;
    logic       tcA, tcB, tcC, tcD;
    logic       stickyA, stickyB, stickyC, stickyD;

    int checks = 0;
    int errors = 0;

    // Counter edges at 5, 15, 25 ... ; outputs are sampled 1 time unit later.
    always #5 clk = ~clk;

    counter_updn_mod #(.WIDTH(4)) dutA (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
        .count_out(countA), .tc(tcA)
`ifdef COUNTER_STICKY_OVF_EN
        , .ovf_clr(ovfClr), .ovf_sticky(stickyA)
`endif
    );

    counter_updn_mod #(.WIDTH(4), .MAX_VAL(11)) dutB (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
        .count_out(countB), .tc(tcB)
`ifdef COUNTER_STICKY_OVF_EN
        , .ovf_clr(ovfClr), .ovf_sticky(stickyB)
`endif
    );

    counter_updn_mod #(.WIDTH(4), .PRESCALE(3)) dutC (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
        .count_out(countC), .tc(tcC)
`ifdef COUNTER_STICKY_OVF_EN
        , .ovf_clr(ovfClr), .ovf_sticky(stickyC)
`endif
    );

    counter_updn_mod #(.WIDTH(4), .SAT_MODE(1)) dutD (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
        .count_out(countD), .tc(tcD)
`ifdef COUNTER_STICKY_OVF_EN
        , .ovf_clr(ovfClr), .ovf_sticky(stickyD)
`endif
    );

`ifndef COUNTER_STICKY_OVF_EN
    assign stickyA = 1'b0;
    assign stickyB = 1'b0;
    assign stickyC = 1'b0;
    assign stickyD = 1'b0;
`endif

    // Drive one cycle of inputs, let the edge happen, then settle.
    task automatic applyStimulus(input logic iRst, input logic iEn, input logic iUp,
                                 input logic iLoad, input logic [3:0] iLoadVal);
        rst     = iRst;
        en      = iEn;
        up      = iUp;
        load    = iLoad;
        loadVal = iLoadVal;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic resetAll();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expCount [11];
        logic enPat  [11];
        expCount = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
        enPat    = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};

        // 1. reset with en high, then counting resumes one per clock
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("rst_count", int'(countA), 0);
        checkOutput("rst_tc", int'(tcA), 0);
        checkOutput("rst_countD", int'(countD), 0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("post_rst_count%0d", i), int'(countA), i);
        end

        // 2. full up sweep with wrap and a single tc pulse
        resetAll();
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("up_count%0d", i), int'(countA), i % 16);
            checkOutput($sformatf("up_tc%0d", i), int'(tcA), (i == 16) ? 1 : 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("after_wrap_count", int'(countA), 1);
        checkOutput("after_wrap_tc", int'(tcA), 0);

        // 3. hold while disabled, then down from 0 wraps to 15
        resetAll();
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("reach7", int'(countA), 7);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("hold7_%0d", i), int'(countA), 7);
        end
        resetAll();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("down_wrap_count", int'(countA), 15);
        checkOutput("down_wrap_tc", int'(tcA), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("down_count14", int'(countA), 14);
        checkOutput("down_tc14", int'(tcA), 0);

        // 4. load beats enable, load clamps to MAX_VAL, reset beats load
        resetAll();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
        checkOutput("load9_A", int'(countA), 9);
        checkOutput("load9_B", int'(countB), 9);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd14);
        checkOutput("load14_A", int'(countA), 14);
        checkOutput("load14_clampB", int'(countB), 11);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("B_at_max_wrap", int'(countB), 0);
        checkOutput("B_at_max_tc", int'(tcB), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        checkOutput("rst_load_A", int'(countA), 0);
        checkOutput("rst_load_B", int'(countB), 0);

        // 5. prescale by 3, including an enable gap mid-interval
        resetAll();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, enPat[i], 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("pre_count%0d", i), int'(countC), expCount[i]);
        end
        // reset in the middle of an interval throws away the partial count
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("pre_rst_partial", int'(countC), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("pre_rst_step", int'(countC), 1);

        // 6. saturation at both ends with tc on every saturated step
        resetAll();
        checkOutput("sat_sticky_rst", int'(stickyD), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("sat_down_count", int'(countD), 0);
        checkOutput("sat_down_tc", int'(tcD), 1);
`ifdef COUNTER_STICKY_OVF_EN
        checkOutput("sticky_set", int'(stickyD), 1);
        ovfClr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        ovfClr = 1'b0;
        checkOutput("sticky_clr", int'(stickyD), 0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd15);
        checkOutput("sat_load15", int'(countD), 15);
        checkOutput("sat_load_tc", int'(tcD), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("sat_hold%0d", i), int'(countD), 15);
            checkOutput($sformatf("sat_tc%0d", i), int'(tcD), 1);
        end
`ifdef COUNTER_STICKY_OVF_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("sticky_holds", int'(stickyD), 1);
        ovfClr = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("sticky_set_wins", int'(stickyD), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        ovfClr = 1'b0;
        checkOutput("sticky_clr2", int'(stickyD), 0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("sat_idle_tc", int'(tcD), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
